audio_loop_buffer: RTL and testbench

AUDIO_LOOP_BUFFER -- requirements
Module: audio_loop_buffer

---
 rtl/audio_loop_buffer.sv | 139 +++++++++++++
 tb/tb_audio_loop_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_loop_buffer.sv
// Record/playback loop buffer between an AC97 codec and a single-port sample RAM.
// Playback samples reach to_ac97_audio on the second edge after their ready strobe.
module audio_loop_buffer #(
   parameter int   ADDR_W   = 12,
   parameter logic PLAYBACK = 1'b1,
   parameter logic RECORD   = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ready,
   input  logic              mode,
   input  logic              start,
   input  logic              loop,
   input  logic [11:0]       from_ac97_audio,
   output logic [11:0]       to_ac97_audio,
   output logic              busy,
   output logic              full,
   output logic [ADDR_W:0]   rec_len
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REC  = 2'd1;
   localparam logic [1:0] PLAY = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              loop_q, loop_d;
   logic              busy_q;
   logic [11:0]       out_q, out_d;
   logic              rd_vld_q;
   logic [11:0]       rd_dat_q;
   logic              we, re;

   logic [11:0]       mem [DEPTH];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      loop_d  = loop_q;
      we      = 1'b0;
      re      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (mode == RECORD) begin
                  state_d = REC;
                  addr_d  = '0;
                  len_d   = '0;
               end else if (mode == PLAYBACK && len_q != '0) begin
                  state_d = PLAY;
                  addr_d  = '0;
                  loop_d  = loop;
               end
            end
         end
         REC: begin
            // A sample arriving with the stop command is still stored.
            if (ready) begin
               we     = 1'b1;
               addr_d = addr_q + 1'b1;
               len_d  = len_q + 1'b1;
               if (len_q == DEPTH_LEN - 1'b1) begin
                  state_d = IDLE;
               end
            end
            if (start) begin
               state_d = IDLE;
            end
         end
         PLAY: begin
            if (ready) begin
               re = 1'b1;
               if ({1'b0, addr_q} == len_q - 1'b1) begin
                  addr_d = '0;
                  if (!loop_q) begin
                     state_d = IDLE;
                  end
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
            if (start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // In-flight read data wins over the idle/record silence clearing.
   always_comb begin
      out_d = out_q;
      if (rd_vld_q) begin
         out_d = rd_dat_q;
      end else if (ready && state_q != PLAY && !(state_q == IDLE && start)) begin
         out_d = 12'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         loop_q   <= 1'b0;
         busy_q   <= 1'b0;
         out_q    <= 12'd0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         loop_q   <= loop_d;
         busy_q   <= (state_d != IDLE);
         out_q    <= out_d;
         rd_vld_q <= re;
      end
   end

   always_ff @(posedge clock) begin
      if (we && reset_n) begin
         mem[addr_q] <= from_ac97_audio;
      end
      if (re) begin
         rd_dat_q <= mem[addr_q];
      end
   end

   assign to_ac97_audio = out_q;
   assign busy          = busy_q;
   assign rec_len       = len_q;
   assign full          = (len_q == DEPTH_LEN);

endmodule

// File: tb/tb_audio_loop_buffer.sv
// Bench for audio_loop_buffer: two instances (depth 8 and 4096) on shared stimulus,
// compared every cycle against a sample-queue reference model.
module tb_audio_loop_buffer;

   localparam logic PB = 1'b1;
   localparam logic RC = 1'b0;
   localparam int S_IDLE = 0;
   localparam int S_REC  = 1;
   localparam int S_PLAY = 2;

   logic        clock = 1'b0;
   logic        reset_n, ready, mode, start, loop;
   logic [11:0] din;
   logic [11:0] out_s, out_b;
   logic        busy_s, busy_b, full_s, full_b;
   logic [3:0]  len_s;
   logic [12:0] len_b;

   always #5 clock = ~clock;

   audio_loop_buffer #(.ADDR_W(3)) u_small (
      .clock(clock), .reset_n(reset_n), .ready(ready), .mode(mode), .start(start),
      .loop(loop), .from_ac97_audio(din), .to_ac97_audio(out_s), .busy(busy_s),
      .full(full_s), .rec_len(len_s)
   );

   audio_loop_buffer u_big (
      .clock(clock), .reset_n(reset_n), .ready(ready), .mode(mode), .start(start),
      .loop(loop), .from_ac97_audio(din), .to_ac97_audio(out_b), .busy(busy_b),
      .full(full_b), .rec_len(len_b)
   );

   int n_chk = 0;
   int n_err = 0;

   int          depth [2] = '{8, 4096};
   int          m_st  [2];
   int          m_len [2];
   int          m_pos [2];
   logic        m_lp  [2];
   logic        m_pv  [2];
   logic [11:0] m_pval[2];
   logic [11:0] m_out [2];
   logic [11:0] m_mem [2][4096];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_st[k]  = S_IDLE;
      m_len[k] = 0;
      m_pos[k] = 0;
      m_lp[k]  = 1'b0;
      m_pv[k]  = 1'b0;
      m_out[k] = 12'd0;
   endtask

   // One clock edge of the reference behaviour, using the inputs present at that edge.
   task automatic model_edge(input int k);
      if (m_pv[k])
         m_out[k] = m_pval[k];
      else if (ready && m_st[k] != S_PLAY && !(m_st[k] == S_IDLE && start))
         m_out[k] = 12'd0;
      m_pv[k] = 1'b0;
      case (m_st[k])
         S_IDLE: begin
            if (start) begin
               if (mode == RC) begin
                  m_st[k]  = S_REC;
                  m_len[k] = 0;
               end else if (m_len[k] > 0) begin
                  m_st[k]  = S_PLAY;
                  m_pos[k] = 0;
                  m_lp[k]  = loop;
               end
            end
         end
         S_REC: begin
            if (ready) begin
               m_mem[k][m_len[k]] = din;
               m_len[k]++;
               if (m_len[k] == depth[k]) m_st[k] = S_IDLE;
            end
            if (start) m_st[k] = S_IDLE;
         end
         default: begin
            if (ready) begin
               m_pv[k]   = 1'b1;
               m_pval[k] = m_mem[k][m_pos[k]];
               m_pos[k]  = (m_pos[k] + 1) % m_len[k];
               if (m_pos[k] == 0 && !m_lp[k]) m_st[k] = S_IDLE;
            end
            if (start) m_st[k] = S_IDLE;
         end
      endcase
   endtask

   task automatic check_all();
      check("small_out",  out_s,  m_out[0]);
      check("small_busy", busy_s, m_st[0] != S_IDLE);
      check("small_full", full_s, m_len[0] == depth[0]);
      check("small_len",  len_s,  m_len[0]);
      check("big_out",    out_b,  m_out[1]);
      check("big_busy",   busy_b, m_st[1] != S_IDLE);
      check("big_full",   full_b, m_len[1] == depth[1]);
      check("big_len",    len_b,  m_len[1]);
   endtask

   task automatic cyc(input logic r, input logic s, input logic md, input logic lp,
                      input logic [11:0] d);
      ready = r; start = s; mode = md; loop = lp; din = d;
      @(posedge clock);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      ready = 1'b1; start = 1'b0;
      reset_n = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      check_all();
      @(posedge clock);
      #1;
      check_all();
      reset_n = 1'b1;
      ready = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, RC, 1'b0, 12'h000);
   endtask

   logic [11:0] loop_tab [7] = '{12'h7FF, 12'h800, 12'h123, 12'h7FF, 12'h800, 12'h123, 12'h7FF};

   initial begin
      reset_n = 1'b0; ready = 1'b0; start = 1'b0; mode = RC; loop = 1'b0; din = 12'h000;
      model_reset(0);
      model_reset(1);
      #1;
      check_all();
      @(posedge clock); #1;
      check_all();
      reset_n = 1'b1;

      // Play request with nothing recorded is ignored.
      cyc(1'b0, 1'b1, PB, 1'b0, 12'h000);
      cyc(1'b1, 1'b0, PB, 1'b0, 12'h000);
      check("empty_play_busy", busy_s, 1'b0);
      check("empty_play_out", out_s, 12'h000);

      // Record 1..5, stop, play once; mode/loop toggled while busy.
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b1, 1'b0, PB, 1'b1, 12'(i));
         idle(1);
      end
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      check("rec5_len", len_s, 4'd5);
      cyc(1'b0, 1'b1, PB, 1'b0, 12'h000);
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b1, 1'b0, RC, 1'b1, 12'h000);
         cyc(1'b0, 1'b0, RC, 1'b1, 12'h000);
         check("play_once", out_s, 12'(i));
         idle(1);
      end
      check("play_once_done", busy_s, 1'b0);
      cyc(1'b1, 1'b0, RC, 1'b0, 12'h000);
      check("clear_after_play", out_s, 12'h000);

      // Looped playback of three extreme samples.
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      cyc(1'b1, 1'b0, RC, 1'b0, 12'h7FF);
      cyc(1'b1, 1'b0, RC, 1'b0, 12'h800);
      cyc(1'b1, 1'b0, RC, 1'b0, 12'h123);
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      cyc(1'b0, 1'b1, PB, 1'b1, 12'h000);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b0, PB, 1'b0, 12'h000);
         cyc(1'b0, 1'b0, PB, 1'b0, 12'h000);
         check("loop_seq", out_s, loop_tab[i]);
      end
      check("loop_still_busy", busy_s, 1'b1);
      cyc(1'b0, 1'b1, PB, 1'b0, 12'h000);
      idle(2);

      // Stop coinciding with a sample in REC; start coinciding with ready in IDLE.
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      cyc(1'b1, 1'b0, RC, 1'b0, 12'h011);
      cyc(1'b1, 1'b0, RC, 1'b0, 12'h022);
      cyc(1'b1, 1'b1, RC, 1'b0, 12'h033);
      check("stop_with_ready_len", len_s, 4'd3);
      check("stop_with_ready_busy", busy_s, 1'b0);
      cyc(1'b1, 1'b1, RC, 1'b0, 12'h044);
      check("start_with_ready_len", len_s, 4'd0);
      check("start_with_ready_busy", busy_s, 1'b1);
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      idle(1);

      // Overfill the depth-8 instance; then play it back to confirm no wrap writes.
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b1, 1'b0, RC, 1'b0, 12'h100 + 12'(i));
         if (i == 8) begin
            check("fill_full", full_s, 1'b1);
            check("fill_busy", busy_s, 1'b0);
            check("fill_len", len_s, 4'd8);
         end
      end
      cyc(1'b0, 1'b1, PB, 1'b0, 12'h000);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, PB, 1'b0, 12'h000);
         cyc(1'b0, 1'b0, PB, 1'b0, 12'h000);
         check("fill_playback", out_s, 12'h100 + 12'(i));
      end
      idle(2);

      // Reset in the middle of looped playback.
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, RC, 1'b0, 12'h2A0 + 12'(i));
      cyc(1'b0, 1'b1, RC, 1'b0, 12'h000);
      cyc(1'b0, 1'b1, PB, 1'b1, 12'h000);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, PB, 1'b1, 12'h000);
      do_reset();
      check("rst_busy", busy_s, 1'b0);
      check("rst_out", out_s, 12'h000);
      check("rst_len", len_s, 4'd0);
      cyc(1'b0, 1'b1, PB, 1'b1, 12'h000);
      cyc(1'b1, 1'b0, PB, 1'b1, 12'h000);
      check("play_after_rst", busy_s, 1'b0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                1'($urandom), 1'($urandom), 12'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
